ay8_core: RTL and testbench



---
 rtl/ay8_core.sv | 97 +++++++++
 tb/tb_ay8_core.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ay8_core.sv
// AY8 execution core: a two-byte fetch/execute sequencer around an 8-bit accumulator.
// Each instruction applies one of 15 bitwise logic functions to (acc, immediate).
module ay8_core (
   input  logic       CLK,
   input  logic       RST,
   output logic [7:0] mem_addr,
   output logic       mem_rd,
   input  logic [7:0] mem_rdata,
   output logic [7:0] acc,
   output logic [7:0] pc
);

   typedef enum logic [1:0] {S_OPA, S_OPD, S_IMA, S_IMD} state_t;

   state_t     stateReg, stateNext;
   logic [7:0] pcReg, accReg, opcodeReg, operandReg, addrHoldReg;
   logic       addrPhase;
   logic       writeAcc;
   logic [7:0] luB, luY;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) stateReg <= S_OPA;
      else      stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      addrPhase = 1'b0;
      case (stateReg)
         S_OPA: begin addrPhase = 1'b1; stateNext = S_OPD; end
         S_OPD: stateNext = S_IMA;
         S_IMA: begin addrPhase = 1'b1; stateNext = S_IMD; end
         S_IMD: stateNext = S_OPA;
         default: stateNext = S_OPA;
      endcase
   end

   // Strobe is gated by reset so the bus is idle while RST is low even though
   // the sequencer already sits in S_OPA.
   assign mem_rd   = RST & addrPhase;
   assign mem_addr = addrPhase ? pcReg : addrHoldReg;

   // The immediate is still on the bus in S_IMD, so bypass it into the logic unit.
   assign luB = (stateReg == S_IMD) ? mem_rdata : operandReg;

   always_comb begin
      luY = accReg;
      case (opcodeReg[3:0])
         4'h0: luY = accReg;
         4'h1: luY = accReg | luB;
         4'h2: luY = accReg | ~luB;
         4'h3: luY = 8'hFF;
         4'h4: luY = accReg & luB;
         4'h5: luY = luB;
         4'h6: luY = ~(accReg ^ luB);
         4'h7: luY = ~accReg | luB;
         4'h8: luY = accReg & ~luB;
         4'h9: luY = accReg ^ luB;
         4'hA: luY = ~luB;
         4'hB: luY = ~(accReg & luB);
         4'hC: luY = 8'h00;
         4'hD: luY = ~accReg & luB;
         4'hE: luY = ~(accReg | luB);
         4'hF: luY = ~accReg;
         default: luY = accReg;
      endcase
   end

   assign writeAcc = (stateReg == S_IMD) && (opcodeReg[7:4] == 4'h0) && (opcodeReg[3:0] != 4'h0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pcReg       <= 8'h00;
         accReg      <= 8'h00;
         opcodeReg   <= 8'h00;
         operandReg  <= 8'h00;
         addrHoldReg <= 8'h00;
      end else begin
         case (stateReg)
            S_OPA, S_IMA: begin
               addrHoldReg <= pcReg;
               pcReg       <= pcReg + 8'd1;
            end
            S_OPD: opcodeReg <= mem_rdata;
            S_IMD: begin
               operandReg <= mem_rdata;
               if (writeAcc) accReg <= luY;
            end
            default: ;
         endcase
      end
   end

   assign acc = accReg;
   assign pc  = pcReg;

endmodule

// File: tb/tb_ay8_core.sv
// Directed bench for ay8_core: synchronous byte memory model plus hand-computed
// accumulator/pc/bus expectations for load, logic sweep, NOP, wrap and reset cases.
module tb_ay8_core;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic [7:0] mem_rdata = 8'h00;
   logic [7:0] acc;
   logic [7:0] pc;

   logic [7:0] mem [0:255];
   int nCompared = 0;
   int nMismatch = 0;

   ay8_core dut (
      .CLK(CLK), .RST(RST),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .acc(acc), .pc(pc)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end else begin
         $display("ok   %s: %02h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic clearMem(input logic [7:0] fill);
      for (int i = 0; i < 256; i++) mem[i] = fill;
   endtask

   // Asserts reset for one cycle and releases it on a falling edge.
   task automatic doReset();
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
   endtask

   logic [7:0] sweepExp [1:15] = '{8'h07, 8'hFB, 8'hFF, 8'h02, 8'h06, 8'hFA, 8'hFE,
                                   8'h01, 8'h05, 8'hF9, 8'hFD, 8'h00, 8'h04, 8'hF8, 8'hFC};

   initial begin
      // Reset with arbitrary memory contents
      clearMem(8'h5A);
      RST = 1'b0;
      @(negedge CLK);
      #1;
      check("reset acc", acc, 8'h00);
      check("reset pc", pc, 8'h00);
      check("reset mem_rd", {7'd0, mem_rd}, 8'h00);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check("first fetch addr", mem_addr, 8'h00);
      check("first fetch rd", {7'd0, mem_rd}, 8'h01);

      // Load immediate and bus timing
      clearMem(8'h00);
      mem[0] = 8'h05; mem[1] = 8'h03;
      doReset();
      tick(1);
      check("S_OPD rd", {7'd0, mem_rd}, 8'h00);
      check("S_OPD addr hold", mem_addr, 8'h00);
      tick(1);
      check("S_IMA addr", mem_addr, 8'h01);
      check("S_IMA rd", {7'd0, mem_rd}, 8'h01);
      tick(1);
      check("S_IMD addr hold", mem_addr, 8'h01);
      check("acc before IMD edge", acc, 8'h00);
      tick(1);
      check("load acc", acc, 8'h03);
      check("load pc", pc, 8'h02);

      // Logic sweep: groups of (load 03, op, NOP padding)
      clearMem(8'h00);
      for (int s = 1; s <= 15; s++) begin
         mem[(s-1)*6 + 0] = 8'h05;
         mem[(s-1)*6 + 1] = 8'h03;
         mem[(s-1)*6 + 2] = 8'(s);
         mem[(s-1)*6 + 3] = (s == 3 || s == 12) ? 8'h00 : 8'h06;
      end
      doReset();
      for (int s = 1; s <= 15; s++) begin
         tick(8);
         check($sformatf("sweep sel %0h", s), acc, sweepExp[s]);
         tick(3);
         check($sformatf("sweep hold sel %0h", s), acc, sweepExp[s]);
         tick(1);
      end

      // NOP and illegal opcode
      clearMem(8'h00);
      mem[0] = 8'h05; mem[1] = 8'h03;
      mem[2] = 8'h00; mem[3] = 8'h55;
      mem[4] = 8'hA1; mem[5] = 8'hFF;
      doReset();
      tick(4);
      check("nop pre acc", acc, 8'h03);
      tick(4);
      check("nop 00 acc", acc, 8'h03);
      tick(4);
      check("illegal A1 acc", acc, 8'h03);
      check("illegal pc", pc, 8'h06);

      // PC wrap across 129 instructions
      for (int k = 0; k < 128; k++) begin
         mem[2*k]   = 8'h05;
         mem[2*k+1] = 8'(k + 16);
      end
      doReset();
      tick(509);
      check("wrap pc FF", pc, 8'hFF);
      tick(3);
      check("wrap pc 00", pc, 8'h00);
      check("wrap acc 128", acc, 8'h8F);
      check("wrap refetch addr", mem_addr, 8'h00);
      check("wrap refetch rd", {7'd0, mem_rd}, 8'h01);
      tick(4);
      check("wrap acc 129", acc, 8'h10);
      check("wrap pc 02", pc, 8'h02);

      // Reset asserted in S_IMA of the second instruction
      clearMem(8'h00);
      mem[0] = 8'h05; mem[1] = 8'h03;
      mem[2] = 8'h05; mem[3] = 8'hAA;
      doReset();
      tick(4);
      check("midrst pre acc", acc, 8'h03);
      tick(2);
      check("midrst in S_IMA rd", {7'd0, mem_rd}, 8'h01);
      RST = 1'b0;
      #1;
      check("midrst acc", acc, 8'h00);
      check("midrst pc", pc, 8'h00);
      check("midrst rd", {7'd0, mem_rd}, 8'h00);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check("midrst restart addr", mem_addr, 8'h00);
      @(negedge CLK);
      tick(3);
      check("midrst reload acc", acc, 8'h03);
      check("midrst reload pc", pc, 8'h02);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
